anc_sample_sequencer: RTL and testbench

- Per-sample control FSM for the ANC datapath.
- Each new sample set goes through the same sequence:
  - strobe the input capture register (in_valid);
  - wait for its outvalid;
  - step the FIR MAC across all taps;
  - optionally step the LMS weight update across all taps;
  - flag the anti-noise output ready.
- Sits between the ADC front-end sample strobe and the input capture register / filter / weight-update datapath.
- Detects and reports sample overruns.

---
 rtl/anc_pkg.sv | 17 +
 rtl/anc_tap_counter.sv | 39 +++
 rtl/anc_sample_sequencer.sv | 137 +++++++++++++
 tb/tb_anc_sample_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// Shared definitions for the ANC per-sample sequencer: state encoding and default sizes.
package anc_pkg;

   localparam int ANC_NUM_TAPS = 32;
   localparam int ANC_TAP_W    = 5;
   localparam int ANC_SAMPLE_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WAIT_BUF = 3'd2,
      ST_FILTER   = 3'd3,
      ST_UPDATE   = 3'd4,
      ST_DONE     = 3'd5
   } anc_state_e;

endpackage

// File: rtl/anc_tap_counter.sv
// Tap address counter: counts up from 0 while stepping, flags the last tap, returns to 0 on clear.
module anc_tap_counter
   import anc_pkg::*;
#(
   parameter int NUM_TAPS = ANC_NUM_TAPS,
   parameter int TAP_W    = ANC_TAP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             step_i,
   output logic [TAP_W-1:0] tap_idx_o,
   output logic             last_o
);

   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

   logic [TAP_W-1:0] tap_q, tap_d;

   // Saturates on the last tap so the address never wraps.
   always_comb begin
      tap_d = tap_q;
      if (clear_i)
         tap_d = '0;
      else if (step_i && (tap_q != LAST_TAP))
         tap_d = tap_q + TAP_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tap_q <= '0;
      else
         tap_q <= tap_d;
   end

   assign tap_idx_o = tap_q;
   assign last_o    = (tap_q == LAST_TAP);

endmodule

// File: rtl/anc_sample_sequencer.sv
// Per-sample ANC control FSM: load, wait for capture, FIR pass, optional LMS pass, output ready.
// Optional overrun counter output enabled by defining ANC_OVERRUN_CNT_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   IDLE     | waiting for an enabled sample_req
//   LOAD     | strobe capture register, latch adapt_en
//   WAIT_BUF | waiting for capture register outvalid
//   FILTER   | FIR MAC across all taps
//   UPDATE   | LMS weight update across all taps
//   DONE     | anti-noise output ready; may chain next sample
module anc_sample_sequencer
   import anc_pkg::*;
#(
   parameter int NUM_TAPS = ANC_NUM_TAPS,
   parameter int TAP_W    = ANC_TAP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             adapt_en,
   input  logic             sample_req,
   output logic             buf_load,
   input  logic             buf_valid,
   output logic [TAP_W-1:0] tap_idx,
   output logic             mac_en,
   output logic             mac_clr,
   output logic             wupd_en,
   output logic             y_valid,
   output logic             busy,
   output logic             overrun,
   input  logic             overrun_clr
`ifdef ANC_OVERRUN_CNT_EN
   ,
   output logic [7:0]       overrun_cnt
`endif
);

   anc_state_e state_q, state_d;
   logic       adapt_q, adapt_d;
   logic       overrun_q, overrun_d;
   logic       drop;
   logic       tap_last;
   logic       in_tap_phase;

   assign in_tap_phase = enable && ((state_q == ST_FILTER) || (state_q == ST_UPDATE));

   anc_tap_counter #(
      .NUM_TAPS (NUM_TAPS),
      .TAP_W    (TAP_W)
   ) u_tap_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (!in_tap_phase || tap_last),
      .step_i    (in_tap_phase),
      .tap_idx_o (tap_idx),
      .last_o    (tap_last)
   );

   always_comb begin
      state_d = state_q;
      adapt_d = adapt_q;
      drop    = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (sample_req) state_d = ST_LOAD;
            ST_LOAD: begin
               adapt_d = adapt_en;
               drop    = sample_req;
               state_d = ST_WAIT_BUF;
            end
            ST_WAIT_BUF: begin
               drop = sample_req;
               if (buf_valid) state_d = ST_FILTER;
            end
            ST_FILTER: begin
               drop = sample_req;
               if (tap_last) state_d = adapt_q ? ST_UPDATE : ST_DONE;
            end
            ST_UPDATE: begin
               drop = sample_req;
               if (tap_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = sample_req ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
      // A drop in the same cycle as a clear leaves the flag set.
      overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         adapt_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         adapt_q   <= adapt_d;
         overrun_q <= overrun_d;
      end
   end

   assign buf_load = (state_q == ST_LOAD);
   assign mac_en   = (state_q == ST_FILTER);
   assign mac_clr  = (state_q == ST_FILTER) && (tap_idx == '0);
   assign wupd_en  = (state_q == ST_UPDATE);
   assign y_valid  = (state_q == ST_DONE);
   assign busy     = (state_q != ST_IDLE);
   assign overrun  = overrun_q;

`ifdef ANC_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (drop && overrun_clr)
         ovr_cnt_d = 8'd1;
      else if (overrun_clr)
         ovr_cnt_d = 8'd0;
      else if (drop && (ovr_cnt_q != 8'hFF))
         ovr_cnt_d = ovr_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovr_cnt_q <= 8'd0;
      else
         ovr_cnt_q <= ovr_cnt_d;
   end

   assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Self-checking bench for anc_sample_sequencer with NUM_TAPS=4: vector table, corner sequences, random vs timeline model.
module tb_anc_sample_sequencer;

   localparam int N  = 4;
   localparam int TW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0, adapt_en = 1'b0, sample_req = 1'b0, buf_valid = 1'b0, overrun_clr = 1'b0;
   logic buf_load, mac_en, mac_clr, wupd_en, y_valid, busy, overrun;
   logic [TW-1:0] tap_idx;
`ifdef ANC_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt;
`endif

   anc_sample_sequencer #(.NUM_TAPS(N), .TAP_W(TW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .adapt_en    (adapt_en),
      .sample_req  (sample_req),
      .buf_load    (buf_load),
      .buf_valid   (buf_valid),
      .tap_idx     (tap_idx),
      .mac_en      (mac_en),
      .mac_clr     (mac_clr),
      .wupd_en     (wupd_en),
      .y_valid     (y_valid),
      .busy        (busy),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
`ifdef ANC_OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [8:0] obs;
   assign obs = {buf_load, mac_en, mac_clr, wupd_en, y_valid, busy, overrun, tap_idx};

   int n_chk = 0;
   int n_fail = 0;

   function automatic logic [8:0] mk(input logic bl, me, mc, wu, yv, bz, ov, input int tap);
      logic [TW-1:0] t;
      t = TW'(tap);
      return {bl, me, mc, wu, yv, bz, ov, t};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       en, ad, req, bv;
      logic [8:0] exp;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic en, ad, req, bv, input logic [8:0] exp);
      vec_t v;
      v.en = en; v.ad = ad; v.req = req; v.bv = bv; v.exp = exp;
      tbl.push_back(v);
   endtask

   // Leaves the bench at cycle 3 of a sample (first FILTER cycle, tap 0).
   task automatic start_sample(input logic ad);
      enable = 1'b1; adapt_en = ad; sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      tick();
      buf_valid = 1'b1;
      tick();
      buf_valid = 1'b0;
   endtask

   // Timeline reference model: one sample is described by the cycle its
   // load happens and the cycle its filter pass starts; everything else is offsets.
   int  m_t, m_load, m_fs, m_cnt;
   bit  m_act, m_ad, m_ov;

   function automatic logic [8:0] model_out();
      logic bl, me, mc, wu, yv;
      int   tp, done_at;
      bl = 0; me = 0; mc = 0; wu = 0; yv = 0; tp = 0;
      if (m_act) begin
         done_at = m_fs + (m_ad ? 2*N : N);
         if (m_t == m_load) bl = 1;
         else if (m_fs >= 0 && m_t >= m_fs && m_t < m_fs + N) begin
            me = 1; tp = m_t - m_fs; mc = (tp == 0);
         end else if (m_fs >= 0 && m_ad && m_t >= m_fs + N && m_t < m_fs + 2*N) begin
            wu = 1; tp = m_t - m_fs - N;
         end else if (m_fs >= 0 && m_t == done_at) yv = 1;
      end
      return mk(bl, me, mc, wu, yv, m_act, m_ov, tp);
   endfunction

   task automatic model_step(input logic en, ad, req, bv, clr);
      bit drop;
      int done_at;
      drop = 0;
      done_at = m_fs + (m_ad ? 2*N : N);
      if (m_act && !en) m_act = 0;
      else if (m_act && m_fs >= 0 && m_t == done_at) begin
         if (req) begin m_load = m_t + 1; m_fs = -1; end
         else m_act = 0;
      end else if (m_act) begin
         if (req) drop = 1;
         if (m_t == m_load) m_ad = ad;
         if (m_t > m_load && m_fs < 0 && bv) m_fs = m_t + 1;
      end else if (en && req) begin
         m_act = 1; m_load = m_t + 1; m_fs = -1;
      end
      if (drop) m_ov = 1;
      else if (clr) m_ov = 0;
      if (drop && clr) m_cnt = 1;
      else if (clr) m_cnt = 0;
      else if (drop && m_cnt < 255) m_cnt++;
      m_t++;
   endtask

   initial begin
      // reset state
      #2;
      chk("reset_outputs", obs, 9'd0);
`ifdef ANC_OVERRUN_CNT_EN
      chk("reset_cnt", overrun_cnt, 0);
`endif
      tick(); tick();
      rst_n = 1'b1;
      enable = 1'b1;

      // no-adapt pass then adapt pass with adapt_en dropped mid-filter
      add(1,0,1,0, mk(0,0,0,0,0,0,0,0));
      add(1,0,0,0, mk(1,0,0,0,0,1,0,0));
      add(1,0,0,1, mk(0,0,0,0,0,1,0,0));
      add(1,0,0,0, mk(0,1,1,0,0,1,0,0));
      add(1,0,0,0, mk(0,1,0,0,0,1,0,1));
      add(1,0,0,0, mk(0,1,0,0,0,1,0,2));
      add(1,0,0,0, mk(0,1,0,0,0,1,0,3));
      add(1,0,0,0, mk(0,0,0,0,1,1,0,0));
      add(1,0,0,0, mk(0,0,0,0,0,0,0,0));
      add(1,1,1,0, mk(0,0,0,0,0,0,0,0));
      add(1,1,0,0, mk(1,0,0,0,0,1,0,0));
      add(1,1,0,1, mk(0,0,0,0,0,1,0,0));
      add(1,1,0,0, mk(0,1,1,0,0,1,0,0));
      add(1,0,0,0, mk(0,1,0,0,0,1,0,1));
      add(1,0,0,0, mk(0,1,0,0,0,1,0,2));
      add(1,0,0,0, mk(0,1,0,0,0,1,0,3));
      add(1,0,0,0, mk(0,0,0,1,0,1,0,0));
      add(1,0,0,0, mk(0,0,0,1,0,1,0,1));
      add(1,0,0,0, mk(0,0,0,1,0,1,0,2));
      add(1,0,0,0, mk(0,0,0,1,0,1,0,3));
      add(1,0,0,0, mk(0,0,0,0,1,1,0,0));
      add(1,0,0,0, mk(0,0,0,0,0,0,0,0));
      for (int i = 0; i < tbl.size(); i++) begin
         enable = tbl[i].en; adapt_en = tbl[i].ad; sample_req = tbl[i].req; buf_valid = tbl[i].bv;
         chk($sformatf("vec%0d", i), obs, tbl[i].exp);
         tick();
      end
      sample_req = 0; buf_valid = 0; adapt_en = 0;

      // drops during FILTER; clear coincident with a drop keeps the flag
      start_sample(0);
      tick();
      sample_req = 1;
      tick();
      chk("ovr_set", obs, mk(0,1,0,0,0,1,1,2));
      tick();
`ifdef ANC_OVERRUN_CNT_EN
      chk("ovr_cnt_2", overrun_cnt, 2);
`endif
      overrun_clr = 1;
      tick();
      sample_req = 0; overrun_clr = 0;
      chk("ovr_set_wins", obs, mk(0,0,0,0,1,1,1,0));
`ifdef ANC_OVERRUN_CNT_EN
      chk("ovr_cnt_1", overrun_cnt, 1);
`endif
      overrun_clr = 1;
      tick();
      overrun_clr = 0;
      chk("ovr_cleared", obs, 9'd0);

      // request in DONE chains straight into LOAD
      start_sample(0);
      tick(); tick(); tick(); tick();
      chk("chain_done", obs, mk(0,0,0,0,1,1,0,0));
      sample_req = 1;
      tick();
      sample_req = 0;
      chk("chain_load", obs, mk(1,0,0,0,0,1,0,0));
      enable = 0;
      tick();
      enable = 1;
      chk("abort_idle", obs, 9'd0);

      // enable dropped at FILTER tap 2
      start_sample(0);
      tick(); tick();
      chk("abort_tap2", obs, mk(0,1,0,0,0,1,0,2));
      enable = 0;
      tick();
      enable = 1;
      chk("abort_next", obs, 9'd0);
      tick();
      chk("abort_no_yv", obs, 9'd0);

      // long WAIT_BUF
      sample_req = 1;
      tick();
      sample_req = 0;
      tick();
      for (int i = 0; i < 50; i++) begin
         chk("wait_buf_hold", obs, mk(0,0,0,0,0,1,0,0));
         tick();
      end
      buf_valid = 1;
      tick();
      buf_valid = 0;
      chk("wait_buf_exit", obs, mk(0,1,1,0,0,1,0,0));
      enable = 0;
      tick();

      // requests while disabled are ignored
      sample_req = 1;
      tick();
      sample_req = 0;
      tick();
      chk("disabled_req", obs, 9'd0);
      enable = 1;

      // 300 drops while parked in WAIT_BUF
      sample_req = 1;
      tick();
      sample_req = 0;
      tick();
      for (int i = 0; i < 300; i++) begin
         sample_req = 1;
         tick();
      end
      sample_req = 0;
      chk("many_drops_flag", overrun, 1);
`ifdef ANC_OVERRUN_CNT_EN
      chk("cnt_saturate", overrun_cnt, 255);
`endif
      enable = 0;
      overrun_clr = 1;
      tick();
      overrun_clr = 0;
      enable = 1;
      chk("post_clear", obs, 9'd0);

      // async reset in the middle of UPDATE
      start_sample(1);
      tick(); tick(); tick(); tick(); tick();
      chk("mid_update", obs, mk(0,0,0,1,0,1,0,1));
      #2;
      rst_n = 0;
      #1;
      chk("async_reset", obs, 9'd0);
      @(posedge clk);
      #1;
      rst_n = 1;
      adapt_en = 0;

      // random stimulus against the timeline model
      m_t = 0; m_act = 0; m_ad = 0; m_ov = 0; m_cnt = 0; m_load = 0; m_fs = -1;
      for (int i = 0; i < 3000; i++) begin
         enable      = ($urandom_range(0, 99) < 97);
         sample_req  = ($urandom_range(0, 99) < 15);
         buf_valid   = ($urandom_range(0, 99) < 40);
         adapt_en    = $urandom_range(0, 1);
         overrun_clr = ($urandom_range(0, 99) < 4);
         chk("rand_outputs", obs, model_out());
`ifdef ANC_OVERRUN_CNT_EN
         chk("rand_cnt", overrun_cnt, m_cnt);
`endif
         model_step(enable, adapt_en, sample_req, buf_valid, overrun_clr);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
